// File: rtl/colour_arbiter.sv
// colour_arbiter: round-robin sharing of one registered RGB converter among four requesters
module colour_arbiter #(
  parameter int CONV_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [11:0] colour_in,
  output logic        conv_enable,
  output logic [2:0]  conv_colour,
  input  logic [23:0] conv_rgb,
  output logic [23:0] rgb_out,
  output logic        valid,
  output logic [3:0]  ack,
  output logic [1:0]  gnt_id,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d, conv_colour_q, conv_colour_d;
  logic [1:0]  last_q, last_d, gnt_id_q, gnt_id_d, win;
  logic        conv_enable_q, conv_enable_d, valid_q, valid_d, found;
  logic [3:0]  ack_q, ack_d, eff;
  logic [23:0] rgb_out_q, rgb_out_d;
  always_comb begin
    eff = req & ~ack_q;
    win = last_q;
    found = 1'b0;
    for (int k = 1; k < 5; k++) begin
      if (!found && eff[last_q + 2'(k)]) begin
        win = last_q + 2'(k);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    gnt_id_d = gnt_id_q;
    conv_colour_d = conv_colour_q;
    rgb_out_d = rgb_out_q;
    conv_enable_d = 1'b0;
    valid_d = 1'b0;
    ack_d = 4'b0;
    case (state_q)
      IDLE: if (found) begin
        state_d = ISSUE;
        gnt_id_d = win;
        conv_colour_d = colour_in[3*win +: 3];
        conv_enable_d = 1'b1;
      end
      ISSUE: begin
        state_d = WAIT;
        // rgb is valid CONV_LAT edges after the sampling edge, so it is capturable one edge later
        cnt_d = 3'(CONV_LAT);
      end
      WAIT: if (cnt_q == 3'd0) begin
        state_d = IDLE;
        rgb_out_d = conv_rgb;
        valid_d = 1'b1;
        ack_d = 4'b0001 << gnt_id_q;
        last_d = gnt_id_q;
      end else cnt_d = cnt_q - 3'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= 3'd0;
      last_q <= 2'd3;
      gnt_id_q <= 2'd0;
      conv_colour_q <= 3'd0;
      rgb_out_q <= 24'd0;
      conv_enable_q <= 1'b0;
      valid_q <= 1'b0;
      ack_q <= 4'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      gnt_id_q <= gnt_id_d;
      conv_colour_q <= conv_colour_d;
      rgb_out_q <= rgb_out_d;
      conv_enable_q <= conv_enable_d;
      valid_q <= valid_d;
      ack_q <= ack_d;
    end
  end
  assign conv_enable = conv_enable_q;
  assign conv_colour = conv_colour_q;
  assign rgb_out = rgb_out_q;
  assign valid = valid_q;
  assign ack = ack_q;
  assign gnt_id = gnt_id_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_colour_arbiter.sv
// tb_colour_arbiter: directed checks of colour_arbiter at CONV_LAT=1 (unit a) and CONV_LAT=3 (unit b)
module tb_colour_arbiter;
  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;
  logic [3:0] req_a = '0, req_b = '0, ack_a, ack_b;
  logic [11:0] colour_a = '0, colour_b = '0;
  logic ce_a, ce_b, valid_a, valid_b, busy_a, busy_b;
  logic [2:0] cc_a, cc_b;
  logic [23:0] rgb_a, rgb_b, crgb_a, crgb_b;
  logic [1:0] gnt_a, gnt_b;
  int n_chk = 0, n_fail = 0;
  colour_arbiter #(.CONV_LAT(1)) dut_a (.clk(clk), .rst_n(rst_n), .req(req_a), .colour_in(colour_a),
    .conv_enable(ce_a), .conv_colour(cc_a), .conv_rgb(crgb_a), .rgb_out(rgb_a), .valid(valid_a),
    .ack(ack_a), .gnt_id(gnt_a), .busy(busy_a));
  colour_arbiter #(.CONV_LAT(3)) dut_b (.clk(clk), .rst_n(rst_n), .req(req_b), .colour_in(colour_b),
    .conv_enable(ce_b), .conv_colour(cc_b), .conv_rgb(crgb_b), .rgb_out(rgb_b), .valid(valid_b),
    .ack(ack_b), .gnt_id(gnt_b), .busy(busy_b));
  // converter models: output is only meaningful in the single cycle it is due, garbage otherwise
  logic [1:0] ena = '0;
  logic [3:0] enb = '0;
  logic [2:0] cola [2];
  logic [2:0] colb [4];
  function automatic logic [23:0] conv_map(input logic [2:0] c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction
  always @(posedge clk) begin
    ena <= {ena[0], ce_a};
    cola[1] <= cola[0];
    cola[0] <= cc_a;
    enb <= {enb[2:0], ce_b};
    colb[3] <= colb[2];
    colb[2] <= colb[1];
    colb[1] <= colb[0];
    colb[0] <= cc_b;
  end
  assign crgb_a = ena[1] ? conv_map(cola[1]) : 24'h5A5A5A;
  assign crgb_b = enb[3] ? conv_map(colb[3]) : 24'h5A5A5A;
  typedef struct {
    logic [3:0]  req;
    logic [11:0] col;
    logic [3:0]  ack;
    logic [23:0] rgb;
    logic [1:0]  gnt;
  } vec_t;
  vec_t vecs [9];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic run(input bit u, input string nm, input logic [3:0] eack, input logic [23:0] ergb,
                     input logic [1:0] egnt, input int eedges, input int ebusy, input int een);
    int e, b, en;
    bit seen;
    e = 0; b = 0; en = 0; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      e++;
      seen = u ? valid_b : valid_a;
      if (!seen) begin
        b += int'(u ? busy_b : busy_a);
        en += int'(u ? ce_b : ce_a);
      end
    end
    chk({nm, " edges"}, 64'(e), 64'(eedges));
    chk({nm, " ack"}, 64'(u ? ack_b : ack_a), 64'(eack));
    chk({nm, " rgb"}, 64'(u ? rgb_b : rgb_a), 64'(ergb));
    chk({nm, " gnt"}, 64'(u ? gnt_b : gnt_a), 64'(egnt));
    chk({nm, " busy cycles"}, 64'(b), 64'(ebusy));
    chk({nm, " enable cycles"}, 64'(en), 64'(een));
  endtask
  initial begin
    vecs[0] = '{4'b0100, 12'b000_101_000_000, 4'b0100, 24'hFF00FF, 2'd2};
    vecs[1] = '{4'b0010, 12'b000_000_000_000, 4'b0010, 24'h000000, 2'd1};
    vecs[2] = '{4'b0010, 12'b000_000_001_000, 4'b0010, 24'h0000FF, 2'd1};
    vecs[3] = '{4'b0010, 12'b000_000_010_000, 4'b0010, 24'h00FF00, 2'd1};
    vecs[4] = '{4'b0010, 12'b000_000_011_000, 4'b0010, 24'h00FFFF, 2'd1};
    vecs[5] = '{4'b0010, 12'b000_000_100_000, 4'b0010, 24'hFF0000, 2'd1};
    vecs[6] = '{4'b0010, 12'b000_000_101_000, 4'b0010, 24'hFF00FF, 2'd1};
    vecs[7] = '{4'b0010, 12'b000_000_110_000, 4'b0010, 24'hFFFF00, 2'd1};
    vecs[8] = '{4'b0010, 12'b000_000_111_000, 4'b0010, 24'hFFFFFF, 2'd1};
    #3 rst_n = 1'b0;
    #1;
    chk("async reset a", {ce_a, cc_a, rgb_a, valid_a, ack_a, gnt_a, busy_a}, 64'd0);
    chk("async reset b", {ce_b, cc_b, rgb_b, valid_b, ack_b, gnt_b, busy_b}, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    colour_a = {3'd7, 3'd5, 3'd3, 3'd0};
    req_a = 4'hF;
    run(0, "all4 g0", 4'b0001, 24'h000000, 2'd0, 4, 3, 1);
    run(0, "all4 g1", 4'b0010, 24'h00FFFF, 2'd1, 4, 3, 1);
    run(0, "all4 g2", 4'b0100, 24'hFF00FF, 2'd2, 4, 3, 1);
    run(0, "all4 g3", 4'b1000, 24'hFFFFFF, 2'd3, 4, 3, 1);
    req_a = '0;
    tick();
    chk("all4 idle", {busy_a, valid_a}, 64'd0);
    colour_a = 12'b110_000_000_001;
    req_a = 4'b1001;
    for (int i = 0; i < 4; i++)
      run(0, $sformatf("fair%0d", i), i[0] ? 4'b1000 : 4'b0001, i[0] ? 24'hFFFF00 : 24'h0000FF,
          i[0] ? 2'd3 : 2'd0, 4, 3, 1);
    req_a = '0;
    tick();
    chk("fair idle", {busy_a, valid_a}, 64'd0);
    chk("colour held in idle", 64'(cc_a), 64'(3'b110));
    for (int i = 0; i < 9; i++) begin
      colour_a = vecs[i].col;
      req_a = vecs[i].req;
      run(0, $sformatf("vec%0d", i), vecs[i].ack, vecs[i].rgb, vecs[i].gnt, 4, 3, 1);
      tick();
      chk($sformatf("vec%0d masked regrant", i), {busy_a, valid_a}, 64'd0);
      req_a = '0;
    end
    colour_a = 12'b000_000_010_001;
    req_a = 4'b0001;
    run(0, "pre-reset g0", 4'b0001, 24'h0000FF, 2'd0, 4, 3, 1);
    req_a = 4'b0011;
    tick();
    tick();
    chk("pre-reset wait gnt", {busy_a, gnt_a}, {61'd0, 1'b1, 2'd1});
    #2 rst_n = 1'b0;
    #1;
    chk("mid-wait reset a", {ce_a, cc_a, rgb_a, valid_a, ack_a, gnt_a, busy_a}, 64'd0);
    tick();
    tick();
    tick();
    chk("held reset no ack", {valid_a, ack_a, busy_a}, 64'd0);
    rst_n = 1'b1;
    run(0, "post-reset g0", 4'b0001, 24'h0000FF, 2'd0, 4, 3, 1);
    req_a = '0;
    tick();
    chk("post-reset idle", {busy_a, valid_a}, 64'd0);
    colour_b = 12'b000_011_000_100;
    req_b = 4'b0100;
    tick();
    chk("lat3 issue", {ce_b, cc_b, gnt_b}, {59'd0, 1'b1, 3'b011, 2'd2});
    req_b = 4'b0101;
    run(1, "lat3 g2", 4'b0100, 24'h00FFFF, 2'd2, 5, 4, 0);
    req_b = 4'b0001;
    run(1, "lat3 queued g0", 4'b0001, 24'hFF0000, 2'd0, 6, 5, 1);
    req_b = '0;
    tick();
    chk("lat3 idle", {busy_b, valid_b}, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
